// File: rtl/mult_reduce_lanes.sv
// Multi-lane signed multiply-reduce engine: LANES pipelined multipliers, a registered lane adder,
// and a window accumulator with ready/valid backpressure. Optional bias load: MULT_REDUCE_BIAS_EN.
module mult_reduce_lanes #(
  parameter int DATA_WIDTH   = 12,
  parameter int NUM_ELEMENTS = 5,
  parameter int LANES        = 2,
  parameter int MULT_PIPE    = 2,
  localparam int ACC_WIDTH   = 2 * DATA_WIDTH + $clog2(NUM_ELEMENTS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          mult_reduce_ready_in,
  input  logic                          mult_reduce_valid_in,
  input  logic [LANES*DATA_WIDTH-1:0]   mult_reduce_dataa_in,
  input  logic [LANES*DATA_WIDTH-1:0]   mult_reduce_datab_in,
`ifdef MULT_REDUCE_BIAS_EN
  input  logic signed [ACC_WIDTH-1:0]   mult_reduce_bias_in,
`endif
  input  logic                          mult_reduce_ready_out,
  output logic                          mult_reduce_valid_out,
  output logic [ACC_WIDTH-1:0]          mult_reduce_result_out
);

  localparam int PROD_W     = 2 * DATA_WIDTH;
  localparam int BEATS      = (NUM_ELEMENTS + LANES - 1) / LANES;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TAIL_LANES = NUM_ELEMENTS - (BEATS - 1) * LANES;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic stall, adv, in_hs;

  logic [CNT_W-1:0]         in_beat_q, in_beat_d;
  logic signed [PROD_W-1:0] prod_in [LANES];
  logic signed [PROD_W-1:0] prod_q  [MULT_PIPE][LANES];
  logic signed [PROD_W-1:0] prod_d  [MULT_PIPE][LANES];
  logic [MULT_PIPE-1:0]     mvld_q, mvld_d;

  logic signed [ACC_WIDTH-1:0] lsum_q, lsum_d;
  logic                        lsum_vld_q, lsum_vld_d;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, base;
  logic [CNT_W-1:0]            acc_beat_q, acc_beat_d;
  logic signed [ACC_WIDTH-1:0] res_q, res_d;
  logic                        vout_q, vout_d;

  // No skid buffer: a stalled output freezes the whole pipe, so ready_in is purely combinational.
  assign stall                  = vout_q && !mult_reduce_ready_out;
  assign adv                    = !stall;
  assign mult_reduce_ready_in   = adv;
  assign in_hs                  = mult_reduce_valid_in && adv;
  assign mult_reduce_valid_out  = vout_q;
  assign mult_reduce_result_out = res_q;

  // Lanes past the last element on the final beat are forced to a zero product.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod_in[k] = '0;
      if ((in_beat_q != LAST_BEAT) || (k < TAIL_LANES)) begin
        prod_in[k] = PROD_W'($signed(mult_reduce_dataa_in[k*DATA_WIDTH +: DATA_WIDTH])) *
                     PROD_W'($signed(mult_reduce_datab_in[k*DATA_WIDTH +: DATA_WIDTH]));
      end
    end
  end

  always_comb begin
    prod_d    = prod_q;
    mvld_d    = mvld_q;
    in_beat_d = in_beat_q;
    if (adv) begin
      prod_d[0] = prod_in;
      mvld_d[0] = mult_reduce_valid_in;
      for (int s = 1; s < MULT_PIPE; s++) begin
        prod_d[s] = prod_q[s-1];
        mvld_d[s] = mvld_q[s-1];
      end
      if (in_hs) begin
        in_beat_d = (in_beat_q == LAST_BEAT) ? '0 : in_beat_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    lsum_d     = lsum_q;
    lsum_vld_d = lsum_vld_q;
    if (adv) begin
      lsum_vld_d = mvld_q[MULT_PIPE-1];
      lsum_d     = '0;
      for (int k = 0; k < LANES; k++) begin
        lsum_d = lsum_d + ACC_WIDTH'(prod_q[MULT_PIPE-1][k]);
      end
    end
  end

  always_comb begin
`ifdef MULT_REDUCE_BIAS_EN
    base = (acc_beat_q == '0) ? mult_reduce_bias_in : acc_q;
`else
    base = acc_q;
`endif
    acc_d      = acc_q;
    acc_beat_d = acc_beat_q;
    res_d      = res_q;
    vout_d     = vout_q;
    if (vout_q && mult_reduce_ready_out) begin
      vout_d = 1'b0;
    end
    // A final beat landing in the same cycle as the output handshake reloads without a bubble.
    if (adv && lsum_vld_q) begin
      if (acc_beat_q == LAST_BEAT) begin
        res_d      = base + lsum_q;
        vout_d     = 1'b1;
        acc_d      = '0;
        acc_beat_d = '0;
      end else begin
        acc_d      = base + lsum_q;
        acc_beat_d = acc_beat_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_beat_q  <= '0;
      mvld_q     <= '0;
      lsum_q     <= '0;
      lsum_vld_q <= 1'b0;
      acc_q      <= '0;
      acc_beat_q <= '0;
      res_q      <= '0;
      vout_q     <= 1'b0;
      for (int s = 0; s < MULT_PIPE; s++) begin
        for (int k = 0; k < LANES; k++) begin
          prod_q[s][k] <= '0;
        end
      end
    end else begin
      in_beat_q  <= in_beat_d;
      mvld_q     <= mvld_d;
      lsum_q     <= lsum_d;
      lsum_vld_q <= lsum_vld_d;
      acc_q      <= acc_d;
      acc_beat_q <= acc_beat_d;
      res_q      <= res_d;
      vout_q     <= vout_d;
      prod_q     <= prod_d;
    end
  end

endmodule

// File: tb/tb_mult_reduce_lanes.sv
// Bench for mult_reduce_lanes: directed and random windows scored against an arithmetic window model.
module tb_mult_reduce_lanes;

  localparam int DW    = 12;
  localparam int NE    = 5;
  localparam int LN    = 2;
  localparam int MP    = 2;
  localparam int AW    = 2 * DW + $clog2(NE + 1);
  localparam int LW    = LN * DW;
  localparam int BEATS = (NE + LN - 1) / LN;

  logic          clk = 1'b0;
  logic          rst;
  logic          ready_in;
  logic          valid_in;
  logic [LW-1:0] dataa;
  logic [LW-1:0] datab;
  logic          ready_out;
  logic          valid_out;
  logic [AW-1:0] result_out;
`ifdef MULT_REDUCE_BIAS_EN
  logic signed [AW-1:0] bias = AW'(-10);
`endif

  mult_reduce_lanes #(.DATA_WIDTH(DW), .NUM_ELEMENTS(NE), .LANES(LN), .MULT_PIPE(MP)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .mult_reduce_ready_in   (ready_in),
    .mult_reduce_valid_in   (valid_in),
    .mult_reduce_dataa_in   (dataa),
    .mult_reduce_datab_in   (datab),
`ifdef MULT_REDUCE_BIAS_EN
    .mult_reduce_bias_in    (bias),
`endif
    .mult_reduce_ready_out  (ready_out),
    .mult_reduce_valid_out  (valid_out),
    .mult_reduce_result_out (result_out)
  );

  always #5 clk = ~clk;

  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  int            mbeat    = 0;
  longint        msum     = 0;
  logic [AW-1:0] expq[$];
  int            hs_cyc[$];
  int            fin_cyc  = -1;
  int            rise_cyc = -1;
  logic          prev_vout = 1'b0;

  function automatic logic [LW-1:0] pk(input int x0, input int x1);
    logic [DW-1:0] l0, l1;
    l0 = DW'(x0);
    l1 = DW'(x1);
    return {l1, l0};
  endfunction

  task automatic model_accept(input logic [LW-1:0] a, input logic [LW-1:0] b);
    for (int k = 0; k < LN; k++) begin
      if (mbeat * LN + k < NE)
        msum += longint'($signed(a[k*DW +: DW])) * longint'($signed(b[k*DW +: DW]));
    end
    mbeat++;
    if (mbeat == BEATS) begin
`ifdef MULT_REDUCE_BIAS_EN
      msum += longint'(bias);
`endif
      expq.push_back(AW'(msum));
      fin_cyc = cyc;
      msum  = 0;
      mbeat = 0;
    end
  endtask

  task automatic check_out();
    logic [AW-1:0] e;
    checks++;
    assert (expq.size() != 0) else begin
      failures++;
      $error("FAIL unexpected_result observed=%0d expected=none", $signed(result_out));
    end
    if (expq.size() != 0) begin
      e = expq.pop_front();
      hs_cyc.push_back(cyc);
      checks++;
      assert (result_out === e) else begin
        failures++;
        $error("FAIL result observed=%0d expected=%0d", $signed(result_out), $signed(e));
      end
    end
  endtask

  // One clock: drive, settle, score handshakes seen before the edge, then step past the edge.
  task automatic tick(input logic v, input logic [LW-1:0] a, input logic [LW-1:0] b,
                      input logic ro, output bit acc);
    valid_in  = v;
    dataa     = a;
    datab     = b;
    ready_out = ro;
    #1;
    acc = 1'b0;
    if (!rst) begin
      if (valid_out === 1'b1 && !prev_vout) rise_cyc = cyc;
      prev_vout = valid_out;
      if (valid_out && ro) check_out();
      if (v && ready_in) begin
        acc = 1'b1;
        model_accept(a, b);
      end
    end else begin
      prev_vout = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ro_mode: 0 = hold ready_out low, 1 = high, 2 = random per cycle.
  task automatic send_beat(input logic [LW-1:0] a, input logic [LW-1:0] b, input int ro_mode,
                           output int tries);
    bit got;
    logic ro;
    tries = 0;
    got   = 1'b0;
    do begin
      ro = (ro_mode == 2) ? ($urandom_range(0, 3) != 0) : (ro_mode != 0);
      tick(1'b1, a, b, ro, got);
      tries++;
    end while (!got && tries < 64);
    checks++;
    assert (got) else begin
      failures++;
      $error("FAIL accept_timeout observed=%0d expected=1", got);
    end
  endtask

  task automatic idle(input int n);
    bit g;
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b1, g);
  endtask

  task automatic drain();
    int n;
    bit g;
    n = 0;
    while (expq.size() != 0 && n < 40) begin
      tick(1'b0, '0, '0, 1'b1, g);
      n++;
    end
    idle(6);
    checks++;
    assert (expq.size() == 0) else begin
      failures++;
      $error("FAIL drain observed=%0d expected=0", expq.size());
    end
  endtask

  initial begin
    int   tries;
    bit   g;
    logic [LW-1:0] ra, rb;

    rst = 1'b1; valid_in = 1'b0; dataa = '0; datab = '0; ready_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 3;
    assert (valid_out === 1'b0) else begin failures++; $error("FAIL rst_valid observed=%0b expected=0", valid_out); end
    assert (result_out === '0) else begin failures++; $error("FAIL rst_result observed=%0d expected=0", result_out); end
    assert (ready_in === 1'b1) else begin failures++; $error("FAIL rst_ready observed=%0b expected=1", ready_in); end
    rst = 1'b0;

    // Single window with garbage on the masked tail lane (15), plus latency
    send_beat(pk(1, 2), pk(1, 1), 1, tries);
    send_beat(pk(3, 4), pk(1, 1), 1, tries);
    send_beat(pk(5, 99), pk(1, 99), 1, tries);
    drain();
    checks++;
    assert (rise_cyc - fin_cyc === MP + 2) else begin
      failures++;
      $error("FAIL latency observed=%0d expected=%0d", rise_cyc - fin_cyc, MP + 2);
    end

    // Signed window (-40)
    send_beat(pk(-3, 4), pk(7, -2), 1, tries);
    send_beat(pk(-5, 2), pk(3, 6), 1, tries);
    send_beat(pk(1, -77), pk(-8, 55), 1, tries);
    drain();

    // Back-to-back windows 30 then -5 with no input gaps
    hs_cyc.delete();
    for (int w = 0; w < 2; w++) begin
      for (int bt = 0; bt < BEATS; bt++) begin
        if (w == 0) send_beat(pk(2, 2), pk(3, 3), 1, tries);
        else        send_beat(pk(1, 1), pk(-1, -1), 1, tries);
        checks++;
        assert (tries === 1) else begin
          failures++;
          $error("FAIL b2b_no_idle observed=%0d expected=1", tries);
        end
      end
    end
    drain();
    checks++;
    assert (hs_cyc.size() == 2 && hs_cyc[1] - hs_cyc[0] == BEATS) else begin
      failures++;
      $error("FAIL b2b_slots observed=%0d expected=%0d", hs_cyc.size() == 2 ? hs_cyc[1] - hs_cyc[0] : -1, BEATS);
    end

    // Backpressure: 30 held for 6 cycles, next window (-5) waits intact
    for (int bt = 0; bt < BEATS; bt++) send_beat(pk(2, 2), pk(3, 3), 0, tries);
    for (int i = 0; i < 20 && valid_out !== 1'b1; i++) tick(1'b0, '0, '0, 1'b0, g);
    checks++;
    assert (valid_out === 1'b1) else begin failures++; $error("FAIL bp_rise observed=%0b expected=1", valid_out); end
    for (int i = 0; i < 6; i++) begin
      checks += 2;
      assert (ready_in === 1'b0) else begin failures++; $error("FAIL bp_ready observed=%0b expected=0", ready_in); end
      if (expq.size() != 0)
        assert (result_out === expq[0]) else begin
          failures++;
          $error("FAIL bp_hold observed=%0d expected=%0d", $signed(result_out), $signed(expq[0]));
        end
      tick(1'b1, pk(1, 1), pk(-1, -1), 1'b0, g);
    end
    for (int bt = 0; bt < BEATS; bt++) send_beat(pk(1, 1), pk(-1, -1), 1, tries);
    drain();

    // Bubbles mid-window
    ra = LW'($urandom); rb = LW'($urandom);
    send_beat(ra, rb, 1, tries);
    idle(2);
    ra = LW'($urandom); rb = LW'($urandom);
    send_beat(ra, rb, 1, tries);
    idle(1);
    ra = LW'($urandom); rb = LW'($urandom);
    send_beat(ra, rb, 1, tries);
    drain();

    // Reset after two beats discards the partial window
    send_beat(pk(100, 200), pk(300, 400), 1, tries);
    send_beat(pk(-7, 9), pk(11, -13), 1, tries);
    rst = 1'b1;
    tick(1'b0, '0, '0, 1'b1, g);
    tick(1'b0, '0, '0, 1'b1, g);
    mbeat = 0;
    msum  = 0;
    rst   = 1'b0;
    checks += 3;
    assert (valid_out === 1'b0) else begin failures++; $error("FAIL mid_rst_valid observed=%0b expected=0", valid_out); end
    assert (result_out === '0) else begin failures++; $error("FAIL mid_rst_result observed=%0d expected=0", result_out); end
    assert (ready_in === 1'b1) else begin failures++; $error("FAIL mid_rst_ready observed=%0b expected=1", ready_in); end
    for (int bt = 0; bt < BEATS; bt++) send_beat(pk(bt + 1, -bt), pk(6, 5), 1, tries);
    drain();

    // Random windows with random bubbles and random downstream backpressure
    for (int w = 0; w < 30; w++) begin
      for (int bt = 0; bt < BEATS; bt++) begin
        for (int i = $urandom_range(0, 2); i > 0; i--)
          tick(1'b0, LW'($urandom), LW'($urandom), ($urandom_range(0, 3) != 0), g);
        ra = LW'($urandom); rb = LW'($urandom);
        send_beat(ra, rb, 2, tries);
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
